instr_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the instruction register path.
//  On a request from the control state machine it reads instruction memory at
//  the program counter, waits a fixed memory latency, then latches the word.
//  It delivers the full instruction word and its 4-bit opcode field (ir_out)
//  to the decoder, then advances the PC or applies a pending jump target.

---
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads instruction memory at pc1, waits MEM_LAT cycles,
// latches the word and opcode, then advances the PC or takes a pending jump.
module instr_fetch_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MEM_LAT  = 2,
  parameter int RESET_PC = 0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] imem_data,
  output logic [ADDR_W-1:0] pc1,
  output logic              imem_rd,
  output logic [DATA_W-1:0] instr,
  output logic [3:0]        ir_out,
  output logic              instr_valid,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_pc;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // WAIT exits on the cycle its counter reaches zero, so it lasts MEM_LAT-1 cycles
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!pc_load && fetch_req) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = (MEM_LAT > 1) ? S_WAIT : S_CAPTURE;
      S_WAIT:    if (wait_cnt <= CNT_W'(1)) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_rd = 1'b0;
    busy    = 1'b0;
    case (state)
      S_ISSUE:   begin imem_rd = 1'b1; busy = 1'b1; end
      S_WAIT:    busy = 1'b1;
      S_CAPTURE: busy = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= CNT_W'(MEM_LAT - 1);
    end else if (state == S_WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - CNT_W'(1);
    end
  end

  // A jump seen in the CAPTURE cycle itself is the newest target and wins
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pc1         <= ADDR_W'(RESET_PC);
      pend_vld    <= 1'b0;
      pend_pc     <= '0;
      instr       <= '0;
      ir_out      <= '0;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pc_load) pc1 <= pc_in;
        end
        S_ISSUE, S_WAIT: begin
          if (pc_load) begin
            pend_vld <= 1'b1;
            pend_pc  <= pc_in;
          end
        end
        S_CAPTURE: begin
          instr       <= imem_data;
          ir_out      <= imem_data[DATA_W-1:DATA_W-4];
          instr_valid <= 1'b1;
          if (pc_load)       pc1 <= pc_in;
          else if (pend_vld) pc1 <= pend_pc;
          else               pc1 <= pc1 + ADDR_W'(1);
          pend_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized fetch/jump
// sequences checked against a behavioural program-counter/memory model.
module tb_instr_fetch_unit;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int MEM_LAT = 2;

  logic              clk;
  logic              reset;
  logic              fetch_req;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_in;
  logic [DATA_W-1:0] imem_data;
  logic [ADDR_W-1:0] pc1;
  logic              imem_rd;
  logic [DATA_W-1:0] instr;
  logic [3:0]        ir_out;
  logic              instr_valid;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mdly0, mdly1;
  logic [ADDR_W-1:0] exp_pc;

  instr_fetch_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .RESET_PC(0)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_in(pc_in), .imem_data(imem_data), .pc1(pc1), .imem_rd(imem_rd),
    .instr(instr), .ir_out(ir_out), .instr_valid(instr_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with a two-cycle read latency; junk is presented when no read is in flight
  always @(posedge clk) begin
    mdly0 <= imem_rd ? mem[pc1] : 16'($urandom);
    mdly1 <= mdly0;
  end
  assign imem_data = mdly1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_in = '0;
    tick(); tick();
    reset = 1'b0;
    exp_pc = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc1 !== 16'h0000) begin errors++; $display("FAIL reset_pc1 got %h want 0000", pc1); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", instr); end
    checks++; if (ir_out !== 4'h0) begin errors++; $display("FAIL reset_ir_out got %h want 0", ir_out); end
    checks++; if ({instr_valid, imem_rd, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got valid/rd/busy=%b want 000", {instr_valid, imem_rd, busy});
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    mem[0] = 16'hA123;
    fetch_req = 1'b1;
    tick();  // E0
    fetch_req = 1'b0;
    checks++; if (imem_rd !== 1'b1 || pc1 !== 16'h0000 || busy !== 1'b1) begin
      errors++; $display("FAIL single_issue got rd=%b pc1=%h busy=%b want rd=1 pc1=0000 busy=1", imem_rd, pc1, busy);
    end
    tick();  // E0+1
    checks++; if (imem_rd !== 1'b0 || busy !== 1'b1 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL single_wait got rd=%b busy=%b valid=%b want 0 1 0", imem_rd, busy, instr_valid);
    end
    tick();  // E0+2
    checks++; if (busy !== 1'b1 || instr_valid !== 1'b0 || pc1 !== 16'h0000) begin
      errors++; $display("FAIL single_capture got busy=%b valid=%b pc1=%h want 1 0 0000", busy, instr_valid, pc1);
    end
    tick();  // E0+3
    checks++; if (instr_valid !== 1'b1 || instr !== 16'hA123 || ir_out !== 4'hA || pc1 !== 16'h0001 || busy !== 1'b0) begin
      errors++; $display("FAIL single_valid got valid=%b instr=%h ir=%h pc1=%h busy=%b want 1 a123 a 0001 0",
                         instr_valid, instr, ir_out, pc1, busy);
    end
    tick();
    checks++; if (instr_valid !== 1'b0 || instr !== 16'hA123) begin
      errors++; $display("FAIL single_hold got valid=%b instr=%h want 0 a123", instr_valid, instr);
    end
  endtask

  task automatic test_back_to_back();
    int edge_no;
    int seen;
    int last_edge;
    logic [DATA_W-1:0] want [3];
    do_reset();
    want[0] = 16'h1111; want[1] = 16'h2222; want[2] = 16'h3333;
    for (int i = 0; i < 3; i++) mem[i] = want[i];
    seen = 0; last_edge = 0; edge_no = 0;
    fetch_req = 1'b1;
    while (seen < 3 && edge_no < 30) begin
      tick();
      edge_no++;
      if (instr_valid === 1'b1) begin
        checks++; if (instr !== want[seen]) begin
          errors++; $display("FAIL b2b_data[%0d] got %h want %h", seen, instr, want[seen]);
        end
        if (seen > 0) begin
          checks++; if (edge_no - last_edge != MEM_LAT + 2) begin
            errors++; $display("FAIL b2b_gap[%0d] got %0d want %0d", seen, edge_no - last_edge, MEM_LAT + 2);
          end
        end
        last_edge = edge_no;
        seen++;
      end
    end
    fetch_req = 1'b0;
    checks++; if (seen != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", seen); end
    tick();
    checks++; if (pc1 !== 16'h0003 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end got pc1=%h busy=%b want 0003 0", pc1, busy);
    end
  endtask

  task automatic test_load_idle();
    pc_load = 1'b1; pc_in = 16'h0040; fetch_req = 1'b1;
    tick();
    pc_load = 1'b0; fetch_req = 1'b0;
    checks++; if (pc1 !== 16'h0040 || busy !== 1'b0 || imem_rd !== 1'b0) begin
      errors++; $display("FAIL load_idle got pc1=%h busy=%b rd=%b want 0040 0 0", pc1, busy, imem_rd);
    end
    tick();
    checks++; if (busy !== 1'b0 || imem_rd !== 1'b0) begin
      errors++; $display("FAIL load_idle_drop got busy=%b rd=%b want 0 0", busy, imem_rd);
    end
    exp_pc = 16'h0040;
  endtask

  task automatic test_jump_in_wait();
    mem[16'h0040] = 16'h5A5A;
    fetch_req = 1'b1;
    tick();  // ISSUE
    fetch_req = 1'b0;
    tick();  // WAIT
    pc_load = 1'b1; pc_in = 16'h0100;
    tick();  // CAPTURE
    pc_load = 1'b0;
    checks++; if (pc1 !== 16'h0040) begin errors++; $display("FAIL jump_stable got pc1=%h want 0040", pc1); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h5A5A || pc1 !== 16'h0100) begin
      errors++; $display("FAIL jump_wait got valid=%b instr=%h pc1=%h want 1 5a5a 0100", instr_valid, instr, pc1);
    end
    exp_pc = 16'h0100;
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 16'hC0DE;
    pc_load = 1'b1; pc_in = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < MEM_LAT + 1; i++) tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 16'hC0DE || ir_out !== 4'hC || pc1 !== 16'h0000) begin
      errors++; $display("FAIL wrap got valid=%b instr=%h ir=%h pc1=%h want 1 c0de c 0000", instr_valid, instr, ir_out, pc1);
    end
    exp_pc = 16'h0000;
  endtask

  task automatic test_reset_mid_fetch();
    int stray;
    mem[16'h0010] = 16'hBEEF;
    pc_load = 1'b1; pc_in = 16'h0010;
    tick();
    pc_load = 1'b0; fetch_req = 1'b1;
    tick();  // ISSUE
    fetch_req = 1'b0;
    tick();  // WAIT
    reset = 1'b1;
    tick();
    checks++; if (pc1 !== 16'h0000 || instr !== 16'h0000 || ir_out !== 4'h0 ||
                 {instr_valid, imem_rd, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_mid got pc1=%h instr=%h ir=%h valid/rd/busy=%b want 0000 0000 0 000",
                         pc1, instr, ir_out, {instr_valid, imem_rd, busy});
    end
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (instr_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++; if (stray != 0 || instr !== 16'h0000) begin
      errors++; $display("FAIL reset_mid_late got stray=%0d instr=%h want 0 0000", stray, instr);
    end
    exp_pc = '0;
  endtask

  // Random mix of idle jumps and fetches with jumps/requests injected while busy
  task automatic test_random();
    int n;
    logic [ADDR_W-1:0] next_pc;
    logic [DATA_W-1:0] want;
    logic [3:0] want_op;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        exp_pc = 16'($urandom);
        pc_load = 1'b1; pc_in = exp_pc;
        tick();
        pc_load = 1'b0;
        checks++; if (pc1 !== exp_pc) begin errors++; $display("FAIL rnd_idle_load got %h want %h", pc1, exp_pc); end
      end else begin
        mem[exp_pc] = 16'($urandom);
        want = mem[exp_pc];
        want_op = want[DATA_W-1 -: 4];
        next_pc = exp_pc + 16'd1;
        fetch_req = 1'b1;
        tick();
        n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
          checks++; if (pc1 !== exp_pc || busy !== 1'b1) begin
            errors++; $display("FAIL rnd_busy_pc got pc1=%h busy=%b want %h 1", pc1, busy, exp_pc);
          end
          fetch_req = $urandom_range(0, 1);
          if ($urandom_range(0, 2) == 0) begin
            pc_in = 16'($urandom);
            pc_load = 1'b1;
            next_pc = pc_in;
          end else begin
            pc_load = 1'b0;
          end
          tick();
          n++;
        end
        fetch_req = 1'b0; pc_load = 1'b0;
        checks++; if (n != MEM_LAT + 1) begin
          errors++; $display("FAIL rnd_latency got %0d want %0d", n, MEM_LAT + 1);
        end
        checks++; if (instr !== want || ir_out !== want_op || pc1 !== next_pc) begin
          errors++; $display("FAIL rnd_result got instr=%h ir=%h pc1=%h want %h %h %h",
                             instr, ir_out, pc1, want, want_op, next_pc);
        end
        exp_pc = next_pc;
        if ($urandom_range(0, 1) == 1) tick();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'($urandom);
    reset = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; pc_in = '0;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_load_idle();
    test_jump_in_wait();
    test_wrap();
    test_reset_mid_fetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
